// File: rtl/score_display_pkg.sv
// Shared constants, types and helpers for the four-digit scoreboard display.
package score_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low segment/anode idle values.
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Largest displayable score; larger inputs are clamped to this.
    localparam logic [6:0] SCORE_MAX = 7'd99;

    // Blink counter load value: odd states 5, 3, 1 are the off-phases.
    localparam logic [2:0] BLINK_LOAD = 3'd6;

    // Digit slot order; the value doubles as the anode bit position.
    typedef enum logic [1:0] {
        DigRightOnes = 2'd0,
        DigRightTens = 2'd1,
        DigLeftOnes  = 2'd2,
        DigLeftTens  = 2'd3
    } digit_e;

    // Active-low 7-segment pattern, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // Blink counter next state: a load beats a coincident tick.
    function automatic logic [2:0] blink_next(input logic [2:0] cur,
                                              input logic       load,
                                              input logic       tick);
        logic [2:0] nxt;
        nxt = cur;
        if (load) begin
            nxt = BLINK_LOAD;
        end else if (tick && (cur != 3'd0)) begin
            nxt = cur - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins; non-decimal codes also decode to all segments off.
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o = seg_pattern(digit_i);
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Scoreboard display controller: scans two 0-99 scores over four multiplexed
// common-anode digits with anti-ghost blanking, change blink and game-over flash.
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_DIV     = 125_000,
    parameter int unsigned BLANK_CYCLES = 2_000,
    parameter int unsigned BLINK_FRAMES = 50
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [6:0] score_left,
    input  logic [6:0] score_right,
    input  logic       game_over,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [ScanW-1:0]  BlankEnd  = ScanW'(BLANK_CYCLES);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

    // The blank window must leave part of each slot lit, and a slot can be no
    // longer than one second of clock.
    if ((BLANK_CYCLES >= SCAN_DIV) || (SCAN_DIV > CLK_HZ)) begin : g_param_check
        $error("score_display_ctrl: BLANK_CYCLES must be < SCAN_DIV <= CLK_HZ");
    end

    // Scan and blink timing state.
    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    digit_e            digit_idx_q, digit_idx_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              phase_q, phase_d;

    // Frame-latched scores and per-player blink counters.
    logic [6:0] lat_left_q, lat_left_d;
    logic [6:0] lat_right_q, lat_right_d;
    logic [2:0] blink_left_q, blink_left_d;
    logic [2:0] blink_right_q, blink_right_d;

    // Registered pin drivers.
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic       scan_wrap;
    logic       frame_end;
    logic       blink_tick;
    logic [6:0] clamp_left;
    logic [6:0] clamp_right;
    logic       load_left;
    logic       load_right;

    logic       sel_left;
    logic       sel_tens;
    logic [6:0] sel_val;
    logic [2:0] sel_blink;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic [3:0] dec_digit;
    logic       in_blank;
    logic       go_blank;
    logic       dec_blank;
    logic [6:0] dec_seg;

    // Slot, frame and blink-tick boundaries.
    always_comb begin
        scan_wrap  = (scan_cnt_q == ScanLast);
        frame_end  = scan_wrap && (digit_idx_q == DigLeftTens);
        blink_tick = frame_end && (frame_cnt_q == FrameLast);
    end

    // Clamp inputs and detect a change against the latched score at frame end.
    always_comb begin
        clamp_left  = (score_left > SCORE_MAX) ? SCORE_MAX : score_left;
        clamp_right = (score_right > SCORE_MAX) ? SCORE_MAX : score_right;
        load_left   = frame_end && (clamp_left != lat_left_q);
        load_right  = frame_end && (clamp_right != lat_right_q);
    end

    // Next state for the scan sequencer, frame counter and blink phase.
    always_comb begin
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q ^ blink_tick;

        if (scan_wrap) begin
            unique case (digit_idx_q)
                DigRightOnes: digit_idx_d = DigRightTens;
                DigRightTens: digit_idx_d = DigLeftOnes;
                DigLeftOnes:  digit_idx_d = DigLeftTens;
                DigLeftTens:  digit_idx_d = DigRightOnes;
                default:      digit_idx_d = DigRightOnes;
            endcase
        end

        if (frame_end) begin
            frame_cnt_d = (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + 1'b1;
        end
    end

    // Scores only move at frame end so a frame never shows a mix of old and new.
    always_comb begin
        lat_left_d    = frame_end ? clamp_left : lat_left_q;
        lat_right_d   = frame_end ? clamp_right : lat_right_q;
        blink_left_d  = blink_next(blink_left_q, load_left, blink_tick);
        blink_right_d = blink_next(blink_right_q, load_right, blink_tick);
    end

    // Select the current digit's player, split to decimal and decide blanking.
    always_comb begin
        sel_left   = (digit_idx_q == DigLeftOnes) || (digit_idx_q == DigLeftTens);
        sel_tens   = (digit_idx_q == DigLeftTens) || (digit_idx_q == DigRightTens);
        sel_val    = sel_left ? lat_left_q : lat_right_q;
        sel_blink  = sel_left ? blink_left_q : blink_right_q;
        tens_digit = 4'(sel_val / 7'd10);
        ones_digit = 4'(sel_val % 7'd10);
        dec_digit  = sel_tens ? tens_digit : ones_digit;
        go_blank   = game_over && phase_q;
        dec_blank  = go_blank || sel_blink[0] || (sel_tens && (tens_digit == 4'd0));
    end

    seg_decoder u_seg_decoder (
        .digit_i (dec_digit),
        .blank_i (dec_blank),
        .seg_o   (dec_seg)
    );

    // Anodes stay off at the start of each slot so segment changes never ghost.
    always_comb begin
        in_blank = (scan_cnt_q < BlankEnd);
        an_d     = AN_OFF;
        seg_d    = dec_seg;
        dp_d     = 1'b1;

        if (!in_blank) begin
            unique case (digit_idx_q)
                DigRightOnes: an_d = 4'b1110;
                DigRightTens: an_d = 4'b1101;
                DigLeftOnes:  an_d = 4'b1011;
                DigLeftTens:  an_d = 4'b0111;
                default:      an_d = AN_OFF;
            endcase
            // Separator dot sits after the left ones digit.
            dp_d = !((digit_idx_q == DigLeftOnes) && !go_blank);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= DigRightOnes;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b0;
            lat_left_q    <= '0;
            lat_right_q   <= '0;
            blink_left_q  <= '0;
            blink_right_q <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            lat_left_q    <= lat_left_d;
            lat_right_q   <= lat_right_d;
            blink_left_q  <= blink_left_d;
            blink_right_q <= blink_right_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    always_comb begin
        an  = an_q;
        seg = seg_q;
        dp  = dp_q;
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl using a frame-level scoreboard.
module tb_score_display_ctrl;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = SCAN_DIV * 4;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] score_left = '0;
    logic [6:0] score_right = '0;
    logic       game_over = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    score_display_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    typedef struct packed {
        logic [3:0] an_b0;
        logic [3:0] an_b1;
        disp_t      head;
        disp_t      tail;
    } obs_t;

    disp_t sb[$];
    obs_t  obs[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    // Frame-level reference model of the latched display state.
    int m_lat_l, m_lat_r, m_bl_l, m_bl_r, m_phase, m_fcnt;

    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic disp_t slot_exp(input int d);
        disp_t e;
        int    val, bl, dig;
        bit    is_tens, gob, blank;
        val     = (d >= 2) ? m_lat_l : m_lat_r;
        bl      = (d >= 2) ? m_bl_l : m_bl_r;
        is_tens = (d % 2) == 1;
        dig     = is_tens ? val / 10 : val % 10;
        gob     = game_over && (m_phase == 1);
        blank   = gob || (bl % 2 == 1) || (is_tens && dig == 0);
        e.an    = 4'b1111;
        e.an[d] = 1'b0;
        e.seg   = blank ? 7'b1111111 : font(dig);
        e.dp    = (d == 2 && !gob) ? 1'b0 : 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_lat_l = 0; m_lat_r = 0; m_bl_l = 0; m_bl_r = 0; m_phase = 0; m_fcnt = 0;
    endtask

    task automatic model_frame_end(input int l, input int r);
        int cl, cr;
        bit tick;
        cl     = (l > 99) ? 99 : l;
        cr     = (r > 99) ? 99 : r;
        tick   = (m_fcnt == BLINK_FRAMES - 1);
        m_fcnt = tick ? 0 : m_fcnt + 1;
        if (cl != m_lat_l) m_bl_l = 6;
        else if (tick && m_bl_l > 0) m_bl_l--;
        if (cr != m_lat_r) m_bl_r = 6;
        else if (tick && m_bl_r > 0) m_bl_r--;
        m_lat_l = cl;
        m_lat_r = cr;
        if (tick) m_phase ^= 1;
    endtask

    // Advance to the negedge inside cycle 'target' (cycle 0 precedes the first
    // posedge after reset release).
    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk_in);
            cyc++;
        end
    endtask

    task automatic apply_reset(input int l, input int r);
        @(negedge clk_in);
        reset       = 1'b1;
        game_over   = 1'b0;
        score_left  = 7'(l);
        score_right = 7'(r);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        cyc   = 0;
        model_reset();
    endtask

    // Drive one frame, push expected slot contents, capture what the DUT shows.
    task automatic run_frame(input int f, input int l, input int r, input bit g,
                             input bit mid);
        int    base;
        obs_t  o;
        base = f * FRAME_CYC;
        goto(base + 1);
        game_over = g;
        if (!mid) begin
            score_left  = 7'(l);
            score_right = 7'(r);
        end
        for (int d = 0; d < 4; d++) sb.push_back(slot_exp(d));
        for (int d = 0; d < 4; d++) begin
            if (mid && d == 2) begin
                goto(base + 8 * d);
                score_left  = 7'(l);
                score_right = 7'(r);
            end
            goto(base + 8 * d + 1);
            o.an_b0 = an;
            goto(base + 8 * d + 2);
            o.an_b1 = an;
            goto(base + 8 * d + 3);
            o.head = {an, seg, dp};
            goto(base + 8 * d + 8);
            o.tail = {an, seg, dp};
            obs.push_back(o);
        end
        model_frame_end(l, r);
    endtask

    task automatic test_reset();
        disp_t e;
        obs_t  o;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            total++;
            if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
                bad++;
                $display("FAIL reset_hold i=%0d got an=%b seg=%b dp=%b want 1111/1111111/1",
                         i, an, seg, dp);
            end
        end
        reset = 1'b0;
        cyc   = 0;
        model_reset();
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(1, 0, 0, 1'b0, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if ({o.an_b0, o.an_b1} !== 8'hff) begin
                bad++;
                $display("FAIL reset_scan_blank slot=%0d got %b %b want 1111", i, o.an_b0, o.an_b1);
            end
            total++;
            if (o.head !== e) begin
                bad++;
                $display("FAIL reset_scan_head slot=%0d got %h want %h", i, o.head, e);
            end
            total++;
            if (o.tail !== e) begin
                bad++;
                $display("FAIL reset_scan_tail slot=%0d got %h want %h", i, o.tail, e);
            end
        end
    endtask

    task automatic test_split_clamp();
        disp_t e;
        obs_t  o;
        apply_reset(42, 7);
        for (int f = 0; f < 3; f++) run_frame(f, 42, 7, 1'b0, 1'b0);
        apply_reset(120, 0);
        for (int f = 0; f < 3; f++) run_frame(f, 120, 0, 1'b0, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if ({o.an_b0, o.an_b1} !== 8'hff) begin
                bad++;
                $display("FAIL split_blank slot=%0d got %b %b want 1111", i, o.an_b0, o.an_b1);
            end
            total++;
            if (o.head !== e || o.tail !== e) begin
                bad++;
                $display("FAIL split_digit slot=%0d got %h/%h want %h", i, o.head, o.tail, e);
            end
        end
    endtask

    task automatic test_blink();
        disp_t e;
        obs_t  o;
        apply_reset(55, 3);
        for (int f = 0; f < 14; f++) run_frame(f, 55, 3, 1'b0, 1'b0);
        for (int f = 14; f < 29; f++) run_frame(f, 55, 4, 1'b0, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o.head !== e || o.tail !== e) begin
                bad++;
                $display("FAIL blink slot=%0d got %h/%h want %h", i, o.head, o.tail, e);
            end
        end
    endtask

    task automatic test_load_tick_game_over();
        disp_t e;
        obs_t  o;
        apply_reset(0, 0);
        run_frame(0, 0, 0, 1'b0, 1'b0);
        // Frame 1 ends on a blink tick: the change load must win.
        for (int f = 1; f < 6; f++) run_frame(f, 0, 5, 1'b0, 1'b0);
        for (int f = 6; f < 12; f++) run_frame(f, 0, 5, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o.head !== e || o.tail !== e) begin
                bad++;
                $display("FAIL load_tick_go slot=%0d got %h/%h want %h", i, o.head, o.tail, e);
            end
        end
        game_over = 1'b0;
    endtask

    task automatic test_midframe_reset();
        disp_t e;
        obs_t  o;
        apply_reset(0, 0);
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(1, 0, 0, 1'b0, 1'b0);
        run_frame(2, 33, 44, 1'b0, 1'b1);
        // Reset while the left-ones digit is lit, between clock edges.
        goto(3 * FRAME_CYC + 8 * 2 + 5);
        #2 reset = 1'b1;
        #1;
        total++;
        if (an !== 4'b1111) begin
            bad++;
            $display("FAIL async_reset_an got %b want 1111", an);
        end
        total++;
        if (seg !== 7'b1111111 || dp !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_seg got seg=%b dp=%b want 1111111/1", seg, dp);
        end
        @(negedge clk_in);
        score_left  = 7'd0;
        score_right = 7'd0;
        reset       = 1'b0;
        cyc         = 0;
        model_reset();
        // With game_over high, a cleared phase keeps these frames lit.
        run_frame(0, 0, 0, 1'b1, 1'b0);
        run_frame(1, 0, 0, 1'b1, 1'b0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if ({o.an_b0, o.an_b1} !== 8'hff) begin
                bad++;
                $display("FAIL mid_blank slot=%0d got %b %b want 1111", i, o.an_b0, o.an_b1);
            end
            total++;
            if (o.head !== e || o.tail !== e) begin
                bad++;
                $display("FAIL mid_reset slot=%0d got %h/%h want %h", i, o.head, o.tail, e);
            end
        end
        game_over = 1'b0;
    endtask

    initial begin
        test_reset();
        test_split_clamp();
        test_blink();
        test_load_tick_game_over();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
